// File: rtl/regbank_pkg.sv
// regbank_pkg: bank select map, write source codes and arbiter FSM states
package regbank_pkg;
    localparam int unsigned NOP_SEL = 35;
    localparam int unsigned W_SEL   = 34;
    localparam int unsigned PI0_SEL = 28;
    localparam int unsigned PI1_SEL = 29;
    localparam int unsigned PO0_SEL = 30;
    localparam int unsigned PO1_SEL = 31;
    localparam logic [1:0] SRC_CPU = 2'd0;
    localparam logic [1:0] SRC_MEM = 2'd1;
    localparam logic [1:0] SRC_DBG = 2'd2;
    typedef enum logic {NORMAL, FORCE} arb_state_t;
    // Input ports PI0/PI1 sit just above the general registers and are read-only
    function automatic logic sel_is_writable(input int unsigned sel);
        return (sel < PI0_SEL && sel != PI1_SEL) || sel == PO0_SEL || sel == PO1_SEL || sel == W_SEL;
    endfunction
endpackage

// File: rtl/regbank_write_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; pointer remembers the last winner
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last;
    always_comb gnt = !en ? 2'b00 : req == 2'b11 ? (last ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk)
        if (reset) last <= 1'b1;
        else if (|gnt) last <= gnt[1];
endmodule

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: shares the bank write port between CPU, memory-load and debug writers
module regbank_write_arbiter
    import regbank_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int SEL_W        = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic [SEL_W-1:0]  cpu_sel,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_stall,
    input  logic              mem_valid,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    input  logic              dbg_valid,
    input  logic [SEL_W-1:0]  dbg_sel,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              dbg_ready,
    output logic [SEL_W-1:0]  Sel_C,
    output logic [DATA_W-1:0] Data_C,
    output logic              wr_reject,
    output logic [1:0]        reject_src
);
    arb_state_t        state;
    logic [3:0]        starve;
    logic [1:0]        gnt;
    logic              cpu_take, take, legal, pending, sec_en;
    logic [SEL_W-1:0]  take_sel;
    logic [DATA_W-1:0] take_data;
    logic [1:0]        take_src;

    rr_arb2 u_rr (
        .clk   (clk),
        .reset (reset),
        .en    (sec_en),
        .req   ({dbg_valid, mem_valid}),
        .gnt   (gnt)
    );

    always_comb begin
        cpu_stall = reset || state == FORCE;
        cpu_take  = cpu_valid && !cpu_stall;
        sec_en    = !reset && (state == FORCE || !cpu_valid);
        mem_ready = gnt[0];
        dbg_ready = gnt[1];
        pending   = mem_valid || dbg_valid;
        take      = cpu_take || |gnt;
        take_src  = cpu_take ? SRC_CPU : gnt[1] ? SRC_DBG : SRC_MEM;
        take_sel  = cpu_take ? cpu_sel : gnt[1] ? dbg_sel : mem_sel;
        take_data = cpu_take ? cpu_data : gnt[1] ? dbg_data : mem_data;
        legal     = sel_is_writable(32'(take_sel));
    end

    // FORCE lasts one cycle; the counter only survives CPU wins over a pending secondary
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= NORMAL;
            starve     <= '0;
            Sel_C      <= SEL_W'(NOP_SEL);
            Data_C     <= '0;
            wr_reject  <= 1'b0;
            reject_src <= SRC_CPU;
        end else begin
            state  <= NORMAL;
            starve <= '0;
            if (cpu_take && pending) begin
                if (starve + 4'd1 == 4'(STARVE_LIMIT)) state <= FORCE;
                else starve <= starve + 4'd1;
            end
            Sel_C     <= take && legal ? take_sel : SEL_W'(NOP_SEL);
            wr_reject <= take && !legal;
            if (take && legal) Data_C <= take_data;
            if (take && !legal) reject_src <= take_src;
        end
    end
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter: directed plan steps plus random traffic against a cycle model
module tb_regbank_write_arbiter;
    localparam int DATA_W = 16;
    localparam int SEL_W  = 6;
    localparam int LIMIT  = 4;
    localparam int NOP    = 35;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_valid, mem_valid, dbg_valid;
    logic [SEL_W-1:0]  cpu_sel, mem_sel, dbg_sel;
    logic [DATA_W-1:0] cpu_data, mem_data, dbg_data;
    logic              cpu_stall, mem_ready, dbg_ready, wr_reject;
    logic [SEL_W-1:0]  Sel_C;
    logic [DATA_W-1:0] Data_C;
    logic [1:0]        reject_src;

    int checks = 0;
    int errors = 0;
    int m_force, m_cnt, m_last;
    int e_sel, e_data, e_rej, e_src;
    bit acc_cpu, acc_mem, acc_dbg;

    regbank_write_arbiter #(.DATA_W(DATA_W), .SEL_W(SEL_W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_sel(cpu_sel), .cpu_data(cpu_data), .cpu_stall(cpu_stall),
        .mem_valid(mem_valid), .mem_sel(mem_sel), .mem_data(mem_data), .mem_ready(mem_ready),
        .dbg_valid(dbg_valid), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
        .Sel_C(Sel_C), .Data_C(Data_C), .wr_reject(wr_reject), .reject_src(reject_src)
    );

    always #5 clk = ~clk;

    function automatic bit legal(int s);
        return s <= 27 || s == 30 || s == 31 || s == 34;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: combinational handshake checked mid-cycle, registered outputs just after the edge
    task automatic step();
        int s, d, src;
        @(negedge clk);
        acc_cpu = 0; acc_mem = 0; acc_dbg = 0;
        if (!reset) begin
            if (m_force == 0 && cpu_valid) acc_cpu = 1;
            else if (mem_valid && dbg_valid) begin
                if (m_last == 1) acc_mem = 1; else acc_dbg = 1;
            end else begin
                acc_mem = mem_valid;
                acc_dbg = dbg_valid;
            end
        end
        chk("cpu_stall", cpu_stall, reset || m_force != 0);
        chk("mem_ready", mem_ready, acc_mem);
        chk("dbg_ready", dbg_ready, acc_dbg);
        @(posedge clk);
        if (reset) begin
            m_force = 0; m_cnt = 0; m_last = 1;
            e_sel = NOP; e_data = 0; e_rej = 0; e_src = 0;
        end else begin
            if (m_force == 0 && acc_cpu && (mem_valid || dbg_valid)) begin
                m_cnt++;
                if (m_cnt == LIMIT) begin m_force = 1; m_cnt = 0; end
            end else begin
                m_force = 0; m_cnt = 0;
            end
            if (acc_mem) m_last = 0;
            if (acc_dbg) m_last = 1;
            e_rej = 0;
            e_sel = NOP;
            if (acc_cpu || acc_mem || acc_dbg) begin
                s   = acc_cpu ? int'(cpu_sel)  : acc_mem ? int'(mem_sel)  : int'(dbg_sel);
                d   = acc_cpu ? int'(cpu_data) : acc_mem ? int'(mem_data) : int'(dbg_data);
                src = acc_cpu ? 0 : acc_mem ? 1 : 2;
                if (legal(s)) begin e_sel = s; e_data = d; end
                else begin e_rej = 1; e_src = src; end
            end
        end
        #1;
        chk("Sel_C", Sel_C, e_sel);
        chk("Data_C", Data_C, e_data);
        chk("wr_reject", wr_reject, e_rej);
        if (e_rej != 0) chk("reject_src", reject_src, e_src);
    endtask

    initial begin
        reset = 1; cpu_valid = 1; mem_valid = 1; dbg_valid = 1;
        cpu_sel = 9; cpu_data = 16'h1111;
        mem_sel = 3; mem_data = 16'h00AA;
        dbg_sel = 34; dbg_data = 16'h0055;
        m_force = 0; m_cnt = 0; m_last = 1;
        e_sel = NOP; e_data = 0; e_rej = 0; e_src = 0;
        step();
        step();
        chk("t1_reset_sel", Sel_C, 35);
        chk("t1_reset_data", Data_C, 0);
        chk("t1_reset_src", reject_src, 0);
        reset = 0;
        step();
        chk("t1_cpu_first", Sel_C, 9);
        cpu_valid = 0; mem_valid = 0; dbg_valid = 0;
        step();

        cpu_valid = 1; cpu_sel = 5; cpu_data = 16'h1234;
        step();
        cpu_valid = 0;
        chk("t2_sel", Sel_C, 5);
        chk("t2_data", Data_C, 16'h1234);
        step();
        chk("t2_nop", Sel_C, 35);

        mem_valid = 1; mem_sel = 3; mem_data = 16'h00AA;
        dbg_valid = 1; dbg_sel = 34; dbg_data = 16'h0055;
        step();
        chk("t3_first_mem", Sel_C, 3);
        if (acc_mem) mem_valid = 0;
        if (acc_dbg) dbg_valid = 0;
        step();
        chk("t3_second_dbg", Sel_C, 34);
        mem_valid = 0; dbg_valid = 0;
        step();
        chk("t3_idle", Sel_C, 35);

        cpu_valid = 1; cpu_sel = 1; cpu_data = 16'h0101;
        mem_valid = 1; mem_sel = 7; mem_data = 16'hBEEF;
        for (int i = 0; i < LIMIT; i++) begin
            step();
            chk("t4_cpu_write", Sel_C, 1);
        end
        step();
        chk("t4_forced_sel", Sel_C, 7);
        chk("t4_forced_data", Data_C, 16'hBEEF);
        mem_valid = 0;
        step();
        chk("t4_cpu_resumes", Sel_C, 1);
        cpu_valid = 0;

        dbg_valid = 1; dbg_sel = 28; dbg_data = 16'hFFFF;
        step();
        chk("t5_pi_sel", Sel_C, 35);
        chk("t5_pi_rej", wr_reject, 1);
        chk("t5_pi_src", reject_src, 2);
        chk("t5_pi_data", Data_C, 16'h0101);
        dbg_sel = 40;
        step();
        chk("t5_hi_rej", wr_reject, 1);
        chk("t5_hi_data", Data_C, 16'h0101);
        dbg_valid = 0;
        step();

        mem_valid = 1; mem_sel = 12; mem_data = 16'h3C3C;
        reset = 1;
        step();
        chk("t6_reset_nop", Sel_C, 35);
        reset = 0;
        step();
        chk("t6_after_release", Sel_C, 12);
        mem_valid = 0;
        step();

        for (int i = 0; i < 600; i++) begin
            if (!cpu_valid || acc_cpu) begin
                cpu_valid = $urandom_range(0, 2) != 0;
                cpu_sel   = SEL_W'($urandom_range(0, 63));
                cpu_data  = DATA_W'($urandom);
            end
            if (!mem_valid || acc_mem) begin
                mem_valid = $urandom_range(0, 1) != 0;
                mem_sel   = SEL_W'($urandom_range(0, 63));
                mem_data  = DATA_W'($urandom);
            end
            if (!dbg_valid || acc_dbg) begin
                dbg_valid = $urandom_range(0, 1) != 0;
                dbg_sel   = SEL_W'($urandom_range(0, 63));
                dbg_data  = DATA_W'($urandom);
            end
            reset = $urandom_range(0, 59) == 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
